// File: rtl/serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_tx: async-serial frame transmitter (start, LSB-first data,        |
// | optional even parity with SERIAL_TX_PARITY_EN, stop).                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
`ifdef SERIAL_TX_PARITY_EN
        , S_PARITY = 3'd3
`endif
    } state_t;

    localparam logic [15:0] c_cnt_last = 16'(CLKS_PER_BIT - 1);
    localparam logic [5:0]  c_bit_last = 6'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_nxt;
    logic [5:0]          r_bit;
    logic [5:0]          w_bit_nxt;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_nxt;
    logic                r_txd;
    logic                w_txd_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    assign w_bit_end = (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_done_nxt  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = 16'd0;
                    w_bit_nxt   = 6'd0;
                    w_shreg_nxt = data;
`ifdef SERIAL_TX_PARITY_EN
                    w_parity_nxt = ^data;
`endif
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 16'd0;
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_bit == c_bit_last) begin
                        w_bit_nxt = 6'd0;
`ifdef SERIAL_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 6'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
                w_bit_nxt   = 6'd0;
            end
        endcase

        // Line level is derived from the upcoming state so txd is a pure flop output.
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shreg_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_txd_nxt = r_parity;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 6'd0;
            r_shreg <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign ready = (r_state == S_IDLE);
    assign txd   = r_txd;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_tx: directed bench for serial_tx with a frame-level model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_serial_tx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int F = 3 + DATA_W;
`else
    localparam int F = 2 + DATA_W;
`endif
    localparam int LAST = F * CPB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              valid = 1'b0;
    logic              ready, txd, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid),
        .ready(ready), .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame model: m_t counts cycles since accept (0 = idle); level = frame[(m_t-1)/CPB].
    int   m_t = 0;
    bit   m_done = 1'b0;
    logic m_frame [0:40];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_t == 0) begin
                if (valid) begin
                    m_frame[0] = 1'b0;
                    for (int i = 0; i < DATA_W; i++) m_frame[1+i] = data[i];
`ifdef SERIAL_TX_PARITY_EN
                    m_frame[1+DATA_W] = ^data;
`endif
                    m_frame[F-1] = 1'b1;
                    m_t = 1;
                end
            end else if (m_t == LAST) begin
                m_t    = 0;
                m_done = 1'b1;
            end else begin
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_txd",   txd,   (m_t == 0) ? 1'b1 : m_frame[(m_t-1)/CPB]);
            chk("model_busy",  busy,  (m_t != 0));
            chk("model_ready", ready, (m_t == 0));
            chk("model_done",  done,  m_done);
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    bit exp_a5 [0:10] = '{0,1,0,1,0,0,1,0,1,0,1};
`else
    bit exp_a5 [0:9]  = '{0,1,0,1,0,0,1,0,1,1};
`endif

    // Offer a word so that the next rising edge is the accept edge (cycle 0).
    task automatic offer(input logic [DATA_W-1:0] w);
        @(negedge clk);
        data  = w;
        valid = 1'b1;
    endtask

    initial begin
        chk_en = 1'b1;
        // Reset held with random inputs
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_txd", txd, 1'b1);
            chk("rst_ready", ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            valid = 1'($urandom);
            data  = DATA_W'($urandom);
        end
        valid = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 8'hA5 level sequence and done timing
        offer(8'hA5);
        for (int k = 1; k <= LAST + 4; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
            if (k <= LAST) chk("a5_txd", txd, exp_a5[(k-1)/CPB]);
            chk("a5_done", done, (k == LAST + 1));
        end

        // Back-to-back: valid held, 8'h00 then 8'hFF
        offer(8'h00);
        for (int k = 1; k <= 2*LAST + 6; k++) begin
            @(negedge clk);
            if (k == 2) data = 8'hFF;
            if (k == LAST + 20) valid = 1'b0;
            if (k == LAST + 1) begin
                chk("b2b_ready41", ready, 1'b1);
                chk("b2b_done41", done, 1'b1);
            end
            if (k >= LAST + 2 && k <= LAST + 1 + CPB) chk("b2b_start2", txd, 1'b0);
            if (k == LAST + 6) chk("b2b_data2", txd, 1'b1);
            if (k > LAST + 1) chk("b2b_done2", done, (k == 2*LAST + 2));
        end

`ifdef SERIAL_TX_PARITY_EN
        // Parity bit for 8'h07 (odd count -> 1) and 8'h03 (even -> 0)
        offer(8'h07);
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
            if (k >= 37 && k <= 44) chk("par07_txd", txd, 1'b1);
            chk("par07_done", done, (k == 45));
        end
        offer(8'h03);
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
            if (k >= 37 && k <= 40) chk("par03_txd", txd, 1'b0);
        end
`endif

        // Reset during data bit 3 of 8'hC3 (bit 3 is 0)
        offer(8'hC3);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
        end
        chk("pre_rst_txd", txd, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_txd", txd, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_ready", ready, 1'b1);
        chk("async_rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        begin
            int n_done;
            n_done = 0;
            offer(8'h3C);
            for (int k = 1; k <= LAST + 4; k++) begin
                @(negedge clk);
                if (k == 1) valid = 1'b0;
                if (done) n_done++;
                if (k == LAST + 1) chk("post_rst_done", done, 1'b1);
            end
            chk("post_rst_done_count", n_done, 1);
        end

        // Input activity while busy is ignored
        offer(8'h96);
        for (int k = 1; k <= LAST + 2; k++) begin
            @(negedge clk);
            if (k <= LAST) begin
                chk("busy_ready", ready, 1'b0);
                data  = DATA_W'($urandom);
                valid = (k < LAST - 2) ? k[0] : 1'b0;
            end
            if (k == 1 + 2*CPB) chk("busy_bit1", txd, 1'b1);
            if (k == 1 + 7*CPB) chk("busy_bit6", txd, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
